// File: rtl/temporal_encoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : temporal_encoder_if
//  Description : Spike-time input handshake for temporal_encoder.
//                master = binary-domain producer, slave = encoder.
//  Signals     : in_valid  producer -> encoder, spike time offered
//                in_ready  encoder  -> producer, encoder can accept
//                in_value  producer -> encoder, spike time (cycles after
//                          gamma phase 0)
//                in_inf    producer -> encoder, no spike (temporal infinity)
//  Revision    : 1.0  initial release
// ============================================================================
interface temporal_encoder_if #(
  parameter int VALUE_WIDTH = 4
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [VALUE_WIDTH-1:0] in_value;
  logic                   in_inf;

  modport master (
    output in_valid,
    output in_value,
    output in_inf,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_value,
    input  in_inf,
    output in_ready
  );

endinterface : temporal_encoder_if
`default_nettype wire

// File: rtl/temporal_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : temporal_encoder
//  Description : Binary-to-temporal encoder. Accepts binary spike times over
//                a valid/ready handshake and emits each one as a race-logic
//                pulse on q inside a fixed-length gamma cycle. Also generates
//                the per-gamma local reset (gamma_rst) and a phase-0 marker.
//  Parameters  : GAMMA_CYCLE_WIDTH  aclk cycles per gamma cycle (>= 4)
//                PULSE_WIDTH        pulse length in cycles
//                                   (1 .. GAMMA_CYCLE_WIDTH-2)
//                VALUE_WIDTH        width of in_value
//                                   (>= clog2(GAMMA_CYCLE_WIDTH))
//  Ports       : aclk         clock
//                grst         asynchronous active-high reset
//                in_if        slave side of the spike-time handshake
//                q            temporal output (flop driven)
//                gamma_rst    high in the last phase of each gamma cycle
//                gamma_start  high in phase 0 of each gamma cycle
//                busy         active or pending slot holds a value
//  Config      : TEMPORAL_ENC_STEP_EN  when defined, q is a step that stays
//                high from the spike time to the end of the usable window
//                (PULSE_WIDTH ignored); otherwise pulse-width encoding.
//  Revision    : 1.0  initial release
// ============================================================================
module temporal_encoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int VALUE_WIDTH       = 4
) (
  input  logic               aclk,
  input  logic               grst,
  temporal_encoder_if.slave  in_if,
  output logic               q,
  output logic               gamma_rst,
  output logic               gamma_start,
  output logic               busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int PH_W  = $clog2(GAMMA_CYCLE_WIDTH);
  // Wide enough that cur + PULSE_WIDTH never wraps.
  localparam int SUM_W = $clog2(2 * GAMMA_CYCLE_WIDTH);

  localparam logic [PH_W-1:0]        c_ph_last     = PH_W'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [PH_W-1:0]        c_ph_pen      = PH_W'(GAMMA_CYCLE_WIDTH - 2);
  localparam logic [PH_W-1:0]        c_ph_zero     = '0;
  localparam logic [PH_W-1:0]        c_ph_one      = PH_W'(1);
  // Any spike time at or beyond the last phase can never be shown, so it
  // is folded into infinity on entry.
  localparam logic [VALUE_WIDTH-1:0] c_val_inf_min = VALUE_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PH_W-1:0] ph_q,          ph_d;
  logic            pend_valid_q,  pend_valid_d;
  logic            pend_inf_q,    pend_inf_d;
  logic [PH_W-1:0] pend_val_q,    pend_val_d;
  logic            cur_inf_q,     cur_inf_d;
  logic [PH_W-1:0] cur_val_q,     cur_val_d;
  logic            q_q,           q_d;
  logic            gamma_rst_q,   gamma_rst_d;
  logic            gamma_start_q, gamma_start_d;

  // --------------------------------------------------------------------------
  // Input side
  // --------------------------------------------------------------------------
  logic            fire;
  logic            ph_last;
  logic            in_is_inf;
  logic [PH_W-1:0] in_val_trunc;
  logic            in_window;

  assign in_if.in_ready = ~pend_valid_q;
  assign fire           = in_if.in_valid & ~pend_valid_q;
  assign ph_last        = (ph_q == c_ph_last);
  assign in_is_inf      = in_if.in_inf | (in_if.in_value >= c_val_inf_min);
  // Safe: a finite value is below G-1 and therefore fits in PH_W bits.
  assign in_val_trunc   = in_if.in_value[PH_W-1:0];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    ph_d         = ph_last ? c_ph_zero : (ph_q + c_ph_one);
    pend_valid_d = pend_valid_q;
    pend_inf_d   = pend_inf_q;
    pend_val_d   = pend_val_q;
    cur_inf_d    = cur_inf_q;
    cur_val_d    = cur_val_q;

    // Outside the last phase every accepted value lands in the buffer.
    if (fire && !ph_last) begin
      pend_valid_d = 1'b1;
      pend_inf_d   = in_is_inf;
      pend_val_d   = in_val_trunc;
    end

    // Gamma boundary: promote the buffered value, or bypass a value that is
    // being accepted right now (only possible when the buffer is empty),
    // or fall back to no spike.
    if (ph_last) begin
      if (pend_valid_q) begin
        cur_inf_d    = pend_inf_q;
        cur_val_d    = pend_val_q;
        pend_valid_d = 1'b0;
      end else if (fire) begin
        cur_inf_d    = in_is_inf;
        cur_val_d    = in_val_trunc;
      end else begin
        cur_inf_d    = 1'b1;
        cur_val_d    = '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output precompute. All outputs are evaluated for the NEXT phase and the
  // slot contents that will be valid then, so each output pin is a bare
  // flop with no combinational path in front of it.
  // --------------------------------------------------------------------------
`ifdef TEMPORAL_ENC_STEP_EN
  always_comb begin
    in_window = ~cur_inf_d
              & (cur_val_d <= ph_d)
              & (ph_d <= c_ph_pen);
  end
`else
  localparam logic [SUM_W-1:0] c_pw_ext = SUM_W'(PULSE_WIDTH);

  logic [SUM_W-1:0] ph_ext;
  logic [SUM_W-1:0] pulse_end;

  assign ph_ext    = SUM_W'(ph_d);
  assign pulse_end = SUM_W'(cur_val_d) + c_pw_ext;

  always_comb begin
    // The ph <= G-2 term truncates pulses that would run into gamma_rst.
    in_window = ~cur_inf_d
              & (cur_val_d <= ph_d)
              & (ph_ext < pulse_end)
              & (ph_d <= c_ph_pen);
  end
`endif

  always_comb begin
    q_d           = in_window;
    gamma_rst_d   = (ph_d == c_ph_last);
    gamma_start_d = (ph_d == c_ph_zero);
  end

  // --------------------------------------------------------------------------
  // Registers. Asynchronous reset parks the phase on the last slot so the
  // first edge after release opens a fresh gamma cycle at phase 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      ph_q          <= c_ph_last;
      pend_valid_q  <= 1'b0;
      pend_inf_q    <= 1'b1;
      pend_val_q    <= '0;
      cur_inf_q     <= 1'b1;
      cur_val_q     <= '0;
      q_q           <= 1'b0;
      gamma_rst_q   <= 1'b1;
      gamma_start_q <= 1'b0;
    end else begin
      ph_q          <= ph_d;
      pend_valid_q  <= pend_valid_d;
      pend_inf_q    <= pend_inf_d;
      pend_val_q    <= pend_val_d;
      cur_inf_q     <= cur_inf_d;
      cur_val_q     <= cur_val_d;
      q_q           <= q_d;
      gamma_rst_q   <= gamma_rst_d;
      gamma_start_q <= gamma_start_d;
    end
  end

  assign q           = q_q;
  assign gamma_rst   = gamma_rst_q;
  assign gamma_start = gamma_start_q;
  assign busy        = ~cur_inf_q | pend_valid_q;

endmodule : temporal_encoder
`default_nettype wire

// File: tb/tb_temporal_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_temporal_encoder
//  Description : Self-checking bench for temporal_encoder. Accepted spike
//                times push the expected per-gamma q pattern to a scoreboard;
//                a monitor rebuilds the observed pattern every gamma cycle
//                and pops/compares it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_temporal_encoder;

  localparam int G  = 16;
  localparam int PW = 8;
  localparam int VW = 4;

  logic aclk = 1'b0;
  logic grst = 1'b1;
  logic q;
  logic gamma_rst;
  logic gamma_start;
  logic busy;

  temporal_encoder_if #(.VALUE_WIDTH(VW)) in_if ();

  temporal_encoder #(
    .GAMMA_CYCLE_WIDTH (G),
    .PULSE_WIDTH       (PW),
    .VALUE_WIDTH       (VW)
  ) dut (
    .aclk        (aclk),
    .grst        (grst),
    .in_if       (in_if),
    .q           (q),
    .gamma_rst   (gamma_rst),
    .gamma_start (gamma_start),
    .busy        (busy)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Bench-side phase / gamma-cycle reference.
  int tb_ph = G - 1;
  int tb_gc = 0;
  always @(posedge aclk or posedge grst) begin
    if (grst) begin
      tb_ph <= G - 1;
    end else if (tb_ph == G - 1) begin
      tb_ph <= 0;
      tb_gc <= tb_gc + 1;
    end else begin
      tb_ph <= tb_ph + 1;
    end
  end

  // Expected q pattern (bit p = q during phase p) for one spike time.
  function automatic logic [G-1:0] exp_mask(input int v, input bit inf);
    logic [G-1:0] m;
    m = '0;
    if (!inf && v < G - 1) begin
      for (int p = 0; p <= G - 2; p++) begin
`ifdef TEMPORAL_ENC_STEP_EN
        if (p >= v) m[p] = 1'b1;
`else
        if (p >= v && p < v + PW) m[p] = 1'b1;
`endif
      end
    end
    return m;
  endfunction

  typedef struct {
    int           emit_gc;
    logic [G-1:0] mask;
  } exp_t;

  exp_t sb_q[$];

  // Monitor: framing outputs every cycle, q pattern once per gamma cycle.
  logic [G-1:0] obs = '0;
  always @(negedge aclk) begin : mon
    logic [G-1:0] m;
    exp_t         e;
    if (!grst) begin
      check_val("gamma_rst", gamma_rst, tb_ph == G - 1);
      check_val("gamma_start", gamma_start, tb_ph == 0);
      m        = (tb_ph == 0) ? '0 : obs;
      m[tb_ph] = q;
      obs     <= m;
      if (tb_ph == G - 1) begin
        if (sb_q.size() > 0 && sb_q[0].emit_gc == tb_gc) begin
          e = sb_q.pop_front();
          check_val("q_mask", m, e.mask);
        end else begin
          check_val("q_idle", m, '0);
        end
      end
    end
  end

  task automatic wait_ph(input int p);
    int n;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (tb_ph != p && n < 40);
    if (tb_ph != p) check_val("wait_ph_timeout", tb_ph, p);
  endtask

  // Offer one value; called right after a negedge. Leaves in_valid low.
  task automatic send(input int v, input bit inf);
    int           waited;
    int           acc_ph;
    logic [31:0]  vv;
    waited          = 0;
    vv              = v;
    in_if.in_valid  = 1'b1;
    in_if.in_value  = vv[VW-1:0];
    in_if.in_inf    = inf;
    while (!in_if.in_ready && waited < 64) begin
      @(negedge aclk);
      waited++;
    end
    if (!in_if.in_ready) begin
      check_val("accept_timeout", 0, 1);
      in_if.in_valid = 1'b0;
      return;
    end
    acc_ph = tb_ph;
    sb_q.push_back('{emit_gc: tb_gc + 1, mask: exp_mask(v, inf)});
    @(negedge aclk);
    in_if.in_valid = 1'b0;
    // Accepting outside the last phase fills the buffer.
    check_val("ready_after_accept", in_if.in_ready, acc_ph == G - 1);
  endtask

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_value = '0;
    in_if.in_inf   = 1'b0;

    // Reset held with clock running.
    repeat (3) @(negedge aclk);
    check_val("rst_q", q, 0);
    check_val("rst_gamma_rst", gamma_rst, 1);
    check_val("rst_gamma_start", gamma_start, 0);
    check_val("rst_in_ready", in_if.in_ready, 1);
    check_val("rst_busy", busy, 0);
    #2 grst = 1'b0;

    // Basic value and boundaries, each accepted at phase 5.
    wait_ph(5); send(3, 1'b0);
    wait_ph(5); send(0, 1'b0);
    wait_ph(15); wait_ph(7);
    check_val("busy_emit", busy, 1);
    wait_ph(5); send(12, 1'b0);
    wait_ph(5); send(14, 1'b0);
    wait_ph(5); send(15, 1'b0);
    wait_ph(5); send(2, 1'b1);
    wait_ph(15); wait_ph(7);
    check_val("busy_inf", busy, 0);

    // Back-to-back with in_valid effectively held.
    wait_ph(3);
    send(2, 1'b0);
    send(5, 1'b0);
    send(7, 1'b0);

    // Bypass at the last phase with an empty buffer.
    wait_ph(15); wait_ph(15);
    check_val("bypass_ready_in", in_if.in_ready, 1);
    send(4, 1'b0);

    // Reset in the middle of a pulse with a value pending.
    wait_ph(15); wait_ph(5);
    send(3, 1'b0);
    wait_ph(1);
    send(9, 1'b0);
    wait_ph(6);
    check_val("pre_rst_q", q, 1);
    check_val("pre_rst_busy", busy, 1);
    #2 grst = 1'b1;
    #1;
    check_val("async_q_drop", q, 0);
    check_val("async_gamma_rst", gamma_rst, 1);
    check_val("async_in_ready", in_if.in_ready, 1);
    check_val("async_busy", busy, 0);
    sb_q.delete();
    repeat (3) @(negedge aclk);
    #2 grst = 1'b0;
    repeat (3 * G) @(negedge aclk);
    check_val("post_rst_busy", busy, 0);

    repeat (2 * G) @(negedge aclk);
    check_val("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_temporal_encoder
`default_nettype wire
